// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared constants, FSM encoding and GF(2^8) helpers for the AES-256
// inverse round engine.
//   NR             number of AES-256 rounds
//   state_e        engine FSM states (IDLE, ROUND, FINAL)
//   xtime/gmulN    GF(2^8) multiply helpers, polynomial 0x11B
//   inv_shift_rows row r of the column-major state rotated right by r bytes
package aes_dec_pkg;

   localparam int unsigned NR = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2
   } state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul9(input logic [7:0] b);
      logic [7:0] x8;
      x8 = xtime(xtime(xtime(b)));
      return x8 ^ b;
   endfunction

   function automatic logic [7:0] gmul11(input logic [7:0] b);
      logic [7:0] x2;
      logic [7:0] x8;
      x2 = xtime(b);
      x8 = xtime(xtime(x2));
      return x8 ^ x2 ^ b;
   endfunction

   function automatic logic [7:0] gmul13(input logic [7:0] b);
      logic [7:0] x4;
      logic [7:0] x8;
      x4 = xtime(xtime(b));
      x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   function automatic logic [7:0] gmul14(input logic [7:0] b);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

   // Byte (r, c) lives at bits [127-8*(4c+r) -: 8]; it moves to column (c+r) mod 4.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8 * (4 * ((c + r) % 4) + r) -: 8] = s[127 - 8 * (4 * c + r) -: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/InverseSbox.sv
// InverseSbox: AES inverse S-box lookup, purely combinational.
//   data_i  byte to substitute
//   data_o  InvSubBytes(data_i)
module InverseSbox (
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   localparam logic [7:0] InvSbox [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
      8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
      8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
      8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
      8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
      8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
      8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
      8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
      8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
      8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
      8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   assign data_o = InvSbox[data_i];

endmodule

// File: rtl/inv_mix_column.sv
// inv_mix_column: AES InvMixColumns on a single 32-bit column.
//   col_i  input column, byte 0 in bits [31:24]
//   col_o  column multiplied by the {0e,0b,0d,09} circulant matrix over GF(2^8)
module inv_mix_column
   import aes_dec_pkg::*;
(
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);

   logic [7:0] a0, a1, a2, a3;

   assign {a0, a1, a2, a3} = col_i;

   assign col_o = {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                   gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                   gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                   gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};

endmodule

// File: rtl/aes256_inv_round_engine.sv
// aes256_inv_round_engine: iterative AES-256 decryption, one inverse round per clock.
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   start          begin decrypting ciphertext (accepted only in IDLE)
//   abort          drop the block in flight (only when AES_DEC_ABORT_EN is defined)
//   ciphertext     128-bit block, byte 0 in bits [127:120], column-major
//   round_key      key selected by round_key_idx, valid in the same cycle
//   round_key_idx  round key the engine needs this cycle (14 down to 0)
//   busy           block in flight
//   done           one-cycle pulse when plaintext is updated
//   plaintext      last result, held until the next completion
// Optional feature macro: AES_DEC_ABORT_EN
module aes256_inv_round_engine
   import aes_dec_pkg::*;
#(
   parameter int unsigned KIDX_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
`ifdef AES_DEC_ABORT_EN
   input  logic              abort,
`endif
   input  logic [127:0]      ciphertext,
   input  logic [127:0]      round_key,
   output logic [KIDX_W-1:0] round_key_idx,
   output logic              busy,
   output logic              done,
   output logic [127:0]      plaintext
);

   localparam logic [KIDX_W-1:0] IdxFirst = KIDX_W'(NR);
   localparam logic [KIDX_W-1:0] IdxStart = KIDX_W'(NR - 1);

   state_e            fsm_q, fsm_d;
   logic [127:0]      blk_q, blk_d;
   logic [KIDX_W-1:0] ctr_q, ctr_d;
   logic [127:0]      pt_q, pt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              abort_req;

`ifdef AES_DEC_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
   logic [127:0] isr, isb, ark, imc;

   assign isr = inv_shift_rows(blk_q);

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      InverseSbox u_sbox (
         .data_i (isr[127 - 8 * i -: 8]),
         .data_o (isb[127 - 8 * i -: 8])
      );
   end

   assign ark = isb ^ round_key;

   for (genvar c = 0; c < 4; c++) begin : g_imc
      inv_mix_column u_imc (
         .col_i (ark[127 - 32 * c -: 32]),
         .col_o (imc[127 - 32 * c -: 32])
      );
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q <= IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // FSM next state. The last ROUND is the one using key 1; key 0 is FINAL.
   always_comb begin
      fsm_d = fsm_q;
      unique case (fsm_q)
         IDLE: begin
            if (start) fsm_d = ROUND;
         end
         ROUND: begin
            if (abort_req) begin
               fsm_d = IDLE;
            end else if (ctr_q == KIDX_W'(1)) begin
               fsm_d = FINAL;
            end
         end
         FINAL: fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   // FSM output: key index requested from the key store.
   always_comb begin
      round_key_idx = IdxFirst;
      unique case (fsm_q)
         IDLE:    round_key_idx = IdxFirst;
         ROUND:   round_key_idx = ctr_q;
         FINAL:   round_key_idx = '0;
         default: round_key_idx = IdxFirst;
      endcase
   end

   // Datapath and handshake registers.
   always_comb begin
      blk_d  = blk_q;
      ctr_d  = ctr_q;
      pt_d   = pt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      unique case (fsm_q)
         IDLE: begin
            if (start) begin
               blk_d  = ciphertext ^ round_key;
               ctr_d  = IdxStart;
               busy_d = 1'b1;
            end
         end
         ROUND: begin
            if (abort_req) begin
               busy_d = 1'b0;
            end else begin
               blk_d = imc;
               ctr_d = ctr_q - KIDX_W'(1);
            end
         end
         FINAL: begin
            busy_d = 1'b0;
            // Abort beats completion: plaintext keeps its old value.
            if (!abort_req) begin
               pt_d   = ark;
               done_d = 1'b1;
            end
         end
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_q  <= '0;
         ctr_q  <= '0;
         pt_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         blk_q  <= blk_d;
         ctr_q  <= ctr_d;
         pt_q   <= pt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign plaintext = pt_q;

endmodule
